// File: rtl/segment_fade_chaser.sv
// segment_fade_chaser
// Steps a lit "head" through a programmable segment sequence. Every segment
// keeps a brightness level that decays by a selectable fade mode. Each level is
// rendered as PWM on a registered segment output, and the output polarity
// matches a common-anode or common-cathode display.
module segment_fade_chaser #(
    parameter int                           NUM_SEG        = 7,
    parameter int                           FADE_WIDTH     = 4,
    parameter int                           STEP_WIDTH     = 22,
    parameter int                           FADE_DIV_WIDTH = 16,
    parameter int                           SEQ_LEN        = 8,
    parameter int                           SEG_IDX_W      = 3,
    parameter logic [SEQ_LEN*SEG_IDX_W-1:0] SEQ            = 24'hB93988,
    parameter bit                           COMMON_ANODE   = 1'b1,
    localparam int                          IDX_W          = $clog2(SEQ_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               direction,
    input  logic [2:0]         speed,
    input  logic [1:0]         fade_mode,
    output logic [NUM_SEG-1:0] seg_out,
    output logic [IDX_W-1:0]   step_idx,
    output logic               step_pulse
);

    localparam logic [FADE_WIDTH-1:0] LEVEL_MAX = '1;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(SEQ_LEN - 1);
    // Inactive drive level: all-ones on a common-anode display, all-zeros otherwise.
    localparam logic [NUM_SEG-1:0]    SEG_IDLE  = {NUM_SEG{COMMON_ANODE}};

    logic [2:0]                speed_q;
    logic                      dir_q;
    logic [STEP_WIDTH-1:0]     step_timer;
    logic [STEP_WIDTH-1:0]     step_terminal;
    logic                      step_hit;
    logic [IDX_W-1:0]          next_idx;
    logic [SEG_IDX_W-1:0]      head_seg;
    logic [NUM_SEG-1:0]        head_hit;
    logic [FADE_DIV_WIDTH-1:0] fade_div;
    logic                      fade_tick;
    logic [FADE_WIDTH-1:0]     pwm_cnt;
    logic [FADE_WIDTH-1:0]     level [NUM_SEG];
    logic [NUM_SEG-1:0]        pwm_on;

    // Register speed and direction once; only these copies steer the stepper.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            speed_q <= speed;
            dir_q   <= direction;
        end
    end

    // The step period is terminal+1 cycles. Larger speed values give a higher terminal count and slower steps.
    always_comb begin
        step_terminal = {speed_q, {(STEP_WIDTH-3){1'b1}}};
        step_hit      = enable && (step_timer == step_terminal);
    end

    // Compute the next sequence position, wrapping at both ends.
    always_comb begin
        next_idx = step_idx;
        if (dir_q) begin
            next_idx = (step_idx == IDX_LAST) ? '0 : step_idx + 1'b1;
        end else begin
            next_idx = (step_idx == '0) ? IDX_LAST : step_idx - 1'b1;
        end
    end

    // Step timer and position. The strobe rises together with the new step_idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_timer <= '0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
        end else if (step_hit) begin
            step_timer <= '0;
            step_idx   <= next_idx;
            step_pulse <= 1'b1;
        end else begin
            if (enable) begin
                step_timer <= step_timer + 1'b1;
            end
            step_pulse <= 1'b0;
        end
    end

    // Look up the head segment for the current position. Entries >= NUM_SEG match no segment.
    always_comb begin
        head_seg = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (step_idx == IDX_W'(i)) begin
                head_seg = SEQ[i*SEG_IDX_W +: SEG_IDX_W];
            end
        end
    end

    // One-hot map of the segment that is currently the head.
    always_comb begin
        head_hit = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            head_hit[i] = (head_seg == SEG_IDX_W'(i));
        end
    end

    // Free-running fade divider and PWM counter. These run whether or not enable is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fade_div <= '0;
            pwm_cnt  <= '0;
        end else begin
            fade_div <= fade_div + 1'b1;
            pwm_cnt  <= pwm_cnt + 1'b1;
        end
    end

    // The fade tick lasts one cycle and occurs once per divider wrap.
    always_comb begin
        fade_tick = (fade_div == '1);
    end

    // Brightness levels. The head is forced to max, which overrides any fade on the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SEG; i++) begin
                if (head_hit[i]) begin
                    level[i] <= LEVEL_MAX;
                end else begin
                    case (fade_mode)
                        2'b00: level[i] <= '0;
                        2'b01: if (fade_tick) level[i] <= level[i] >> 1;
                        2'b10: if (fade_tick && (level[i] != '0)) level[i] <= level[i] - 1'b1;
                        default: level[i] <= level[i];
                    endcase
                end
            end
        end
    end

    // PWM compare. Level 0 is never on, and max level is on for all but one count.
    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            pwm_on[i] = (level[i] > pwm_cnt);
        end
    end

    // Register the segment drive with the display polarity applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out <= SEG_IDLE;
        end else begin
            seg_out <= pwm_on ^ SEG_IDLE;
        end
    end

endmodule

// File: tb/tb_segment_fade_chaser.sv
// Directed bench for segment_fade_chaser with a short step timer and a fast fade divider.
module tb_segment_fade_chaser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       direction = 1'b1;
    logic [2:0] speed = 3'd0;
    logic [1:0] fade_mode = 2'b00;

    logic [6:0] seg_out, seg_out_cc;
    logic [2:0] step_idx, step_idx_cc;
    logic       step_pulse, step_pulse_cc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cyc_prev = 0;

    typedef struct {
        logic       dir;
        logic [2:0] spd;
        int         exp_idx;
        int         exp_head;
        int         exp_period;
    } step_vec_t;

    step_vec_t tbl [13];

    segment_fade_chaser #(.STEP_WIDTH(6), .FADE_DIV_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .direction(direction),
        .speed(speed), .fade_mode(fade_mode), .seg_out(seg_out),
        .step_idx(step_idx), .step_pulse(step_pulse)
    );

    segment_fade_chaser #(.STEP_WIDTH(6), .FADE_DIV_WIDTH(4), .COMMON_ANODE(1'b0)) dut_cc (
        .clk(clk), .reset(reset), .enable(enable), .direction(direction),
        .speed(speed), .fade_mode(fade_mode), .seg_out(seg_out_cc),
        .step_idx(step_idx_cc), .step_pulse(step_pulse_cc)
    );

    // Clock generation
    initial forever #5 clk = ~clk;

    // Edge counter since the last reset. The PWM count and the fade divider equal cyc mod 16.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic wait_pulse(input int budget);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!step_pulse && waited < budget);
        check("step_pulse_seen", int'(step_pulse), 1);
    endtask

    task automatic sync_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % 16) != 0 && n < 40);
    endtask

    task automatic sample_mask(input int n, output logic [6:0] m);
        m = '0;
        repeat (n) begin
            @(negedge clk);
            m = m | ~seg_out;
        end
    endtask

    // Count the active cycles of two segments over one 16-cycle PWM frame.
    task automatic window(input int sa, input int sb, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!seg_out[sa]) ca++;
            if (!seg_out[sb]) cb++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_seg_out"}, int'(seg_out), 'h7F);
        check({tag, "_seg_out_cc"}, int'(seg_out_cc), 'h00);
        check({tag, "_idx"}, int'(step_idx), 0);
        check({tag, "_pulse"}, int'(step_pulse), 0);
    endtask

    task automatic check_reset_duty(input string tag);
        int c0, cother, cmis;
        c0 = 0;
        cother = 0;
        cmis = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!seg_out[0]) c0++;
            if (seg_out[6:1] != 6'h3F) cother++;
            if (seg_out_cc != ~seg_out || step_idx_cc != step_idx || step_pulse_cc != step_pulse) cmis++;
        end
        check({tag, "_seg0_duty"}, c0, 15);
        check({tag, "_others_dark"}, cother, 0);
        check({tag, "_cc_polarity"}, cmis, 0);
    endtask

    // Called at the negedge where step_pulse is seen. It applies the next
    // direction and speed, then checks the strobe width and which segment is lit.
    task automatic check_step(input string tag, input int exp_idx, input int exp_head,
                              input int exp_period, input logic nxt_dir, input logic [2:0] nxt_spd);
        logic [6:0] m;
        check({tag, "_idx"}, int'(step_idx), exp_idx);
        if (exp_period != 0) check({tag, "_period"}, cyc - cyc_prev, exp_period);
        cyc_prev = cyc;
        direction = nxt_dir;
        speed = nxt_spd;
        @(negedge clk);
        check({tag, "_pulse_width"}, int'(step_pulse), 0);
        sample_mask(4, m);
        check({tag, "_head"}, int'(m), 1 << exp_head);
    endtask

    initial begin
        int ca, cb, cnt_p, cnt_chg, n;
        logic [6:0] m;
        int exp_half [4];
        exp_half = '{7, 3, 1, 0};

        // Figure-8 heads 0,1,6,4,3,2,6,5. The row's inputs are applied at the previous step.
        tbl[0]  = '{1'b1, 3'd0, 2, 6, 8};
        tbl[1]  = '{1'b1, 3'd0, 3, 4, 8};
        tbl[2]  = '{1'b1, 3'd0, 4, 3, 8};
        tbl[3]  = '{1'b1, 3'd0, 5, 2, 8};
        tbl[4]  = '{1'b1, 3'd0, 6, 6, 8};
        tbl[5]  = '{1'b1, 3'd0, 7, 5, 8};
        tbl[6]  = '{1'b1, 3'd0, 0, 0, 8};
        tbl[7]  = '{1'b1, 3'd0, 1, 1, 8};
        tbl[8]  = '{1'b0, 3'd0, 0, 0, 8};
        tbl[9]  = '{1'b0, 3'd0, 7, 5, 8};
        tbl[10] = '{1'b0, 3'd1, 6, 6, 16};
        tbl[11] = '{1'b0, 3'd1, 5, 2, 16};
        tbl[12] = '{1'b1, 3'd0, 6, 6, 8};

        // Reset held
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        reset = 1'b0;
        check_reset_duty("rst_release");

        // Stepping sequence, forward and reverse, two speeds
        enable = 1'b1;
        direction = 1'b1;
        speed = 3'd0;
        wait_pulse(40);
        check_step("sync", 1, 1, 0, tbl[0].dir, tbl[0].spd);
        for (int i = 0; i < 13; i++) begin
            wait_pulse(40);
            if (i < 12) check_step($sformatf("step%0d", i), tbl[i].exp_idx, tbl[i].exp_head,
                                   tbl[i].exp_period, tbl[i+1].dir, tbl[i+1].spd);
            else        check_step($sformatf("step%0d", i), tbl[i].exp_idx, tbl[i].exp_head,
                                   tbl[i].exp_period, 1'b1, 3'd0);
        end

        // Halving fade: segment 6 leaves the head when idx 6 -> 7 (head 5)
        fade_mode = 2'b01;
        wait_pulse(40);
        enable = 1'b0;
        check("fade01_idx", int'(step_idx), 7);
        sync_tick();
        for (int k = 0; k < 4; k++) begin
            window(6, 5, ca, cb);
            check($sformatf("fade01_seg6_w%0d", k), ca, exp_half[k]);
            check($sformatf("fade01_seg5_w%0d", k), cb, 15);
        end

        // Linear fade: segment 5 leaves the head when idx 7 -> 0 (head 0)
        fade_mode = 2'b10;
        enable = 1'b1;
        wait_pulse(40);
        enable = 1'b0;
        check("fade10_idx", int'(step_idx), 0);
        sync_tick();
        for (int k = 0; k < 16; k++) begin
            window(5, 0, ca, cb);
            check($sformatf("fade10_seg5_w%0d", k), ca, (k < 14) ? 14 - k : 0);
            check($sformatf("fade10_seg0_w%0d", k), cb, 15);
        end

        // Freeze: segment 0 leaves the head when idx 0 -> 1 (head 1) and holds max
        fade_mode = 2'b11;
        enable = 1'b1;
        wait_pulse(40);
        enable = 1'b0;
        check("fade11_idx", int'(step_idx), 1);
        sync_tick();
        for (int k = 0; k < 2; k++) begin
            window(0, 1, ca, cb);
            check($sformatf("fade11_seg0_w%0d", k), ca, 15);
            check($sformatf("fade11_seg1_w%0d", k), cb, 15);
        end

        // No trail: only the head stays lit
        fade_mode = 2'b00;
        repeat (2) @(negedge clk);
        sample_mask(16, m);
        check("nofade_lit_mask", int'(m), 'h02);

        // Enable dropped mid-step for 20 cycles
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        cnt_p = 0;
        cnt_chg = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (step_pulse) cnt_p++;
            if (step_idx != 3'd1) cnt_chg++;
        end
        check("freeze_pulses", cnt_p, 0);
        check("freeze_idx_moves", cnt_chg, 0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse && n < 40);
        check("freeze_resume_cycles", n, 5);
        check("freeze_resume_idx", int'(step_idx), 2);
        enable = 1'b0;

        // Async reset pulse between clock edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_state("async_rst");
        #1 reset = 1'b0;
        check_reset_duty("async_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
